// File: rtl/cmd_frame_pkg.sv
// Shared opcodes, command encodings and FSM state codes for the
// UART command-frame master.
package cmd_frame_pkg;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU = 8'hCC;
  localparam logic [7:0] OP_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR  = 2'd0,
    CMD_RD  = 2'd1,
    CMD_ALU = 2'd2,
    CMD_NOP = 2'd3
  } cmd_type_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] opcode(input cmd_type_t t);
    case (t)
      CMD_WR:  return OP_WR;
      CMD_RD:  return OP_RD;
      CMD_ALU: return OP_ALU;
      default: return OP_NOP;
    endcase
  endfunction

  // Index of the final frame byte for each command type
  function automatic logic [1:0] last_idx(input cmd_type_t t);
    case (t)
      CMD_WR:  return 2'd2;
      CMD_RD:  return 2'd1;
      CMD_ALU: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_type_t t);
    case (t)
      CMD_WR:  return 2'd0;
      CMD_RD:  return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_master_timer.sv
// Per-byte response timer: clears on demand, counts while enabled,
// flags expiry one cycle short of the limit (limit 0 never expires).
module cmd_rsp_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign expire = en && (lim != '0) &&
                  (count == lim - W'(1));

endmodule

// File: rtl/cmd_frame_master.sv
// Builds AA/BB/CC/DD command frames, streams them to UART TX and
// gathers the response bytes from UART RX into one response word.
module cmd_frame_master
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH-1:0]   cmd_op_a,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [FUN_WIDTH-1:0]    cmd_fun,
  input  logic [TIMEOUT_W-1:0]    timeout_lim,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_valid,
  output logic                    rsp_timeout
);

  state_t                  state;
  cmd_type_t               typ_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   op_a_q;
  logic [DATA_WIDTH-1:0]   op_b_q;
  logic [FUN_WIDTH-1:0]    fun_q;
  logic [1:0]              tx_idx;
  logic [1:0]              nxt_idx;
  logic                    rx_idx;
  logic                    last_tx;
  logic                    last_rx;
  logic                    expire;
  logic                    tmr_en;
  logic                    tmr_clr;
  logic [DATA_WIDTH-1:0]   nxt_byte;

  assign nxt_idx = tx_idx + 2'd1;
  assign last_tx = (tx_idx == last_idx(typ_q));
  assign last_rx = (({1'b0, rx_idx} + 2'd1) == rsp_len(typ_q));
  assign tmr_en  = (state == S_WAIT);
  assign tmr_clr = !tmr_en || RX_D_VLD;

  cmd_rsp_timer #(.W(TIMEOUT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .lim    (timeout_lim),
    .expire (expire)
  );

  // Payload byte following the current one; byte 0 is always the opcode
  always_comb begin
    nxt_byte = '0;
    case ({typ_q, nxt_idx})
      {CMD_WR, 2'd1},
      {CMD_RD, 2'd1}:  nxt_byte = DATA_WIDTH'(addr_q);
      {CMD_WR, 2'd2}:  nxt_byte = wdata_q;
      {CMD_ALU, 2'd1}: nxt_byte = op_a_q;
      {CMD_ALU, 2'd2}: nxt_byte = op_b_q;
      {CMD_ALU, 2'd3},
      {CMD_NOP, 2'd1}: nxt_byte = DATA_WIDTH'(fun_q);
      default:         nxt_byte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      typ_q       <= CMD_WR;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      fun_q       <= '0;
      tx_idx      <= '0;
      rx_idx      <= 1'b0;
      cmd_ready   <= 1'b1;
      TX_D_VLD    <= 1'b0;
      TX_P_DATA   <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            typ_q     <= cmd_type_t'(cmd_type);
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            op_a_q    <= cmd_op_a;
            op_b_q    <= cmd_op_b;
            fun_q     <= cmd_fun;
            tx_idx    <= '0;
            rx_idx    <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            TX_D_VLD  <= 1'b1;
            TX_P_DATA <= DATA_WIDTH'(opcode(cmd_type_t'(cmd_type)));
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (last_tx) begin
              TX_D_VLD  <= 1'b0;
              TX_P_DATA <= '0;
              if (rsp_len(typ_q) == 2'd0) begin
                state     <= S_DONE;
                rsp_valid <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              tx_idx    <= nxt_idx;
              TX_P_DATA <= nxt_byte;
            end
          end
        end
        S_WAIT: begin
          // A byte arriving on the expiry cycle takes priority
          if (RX_D_VLD) begin
            if (rx_idx) begin
              rsp_data[DATA_WIDTH +: DATA_WIDTH] <= RX_P_DATA;
            end else begin
              rsp_data[0 +: DATA_WIDTH] <= RX_P_DATA;
            end
            if (last_rx) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
            end else begin
              rx_idx <= 1'b1;
            end
          end else if (expire) begin
            state       <= S_DONE;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_master.sv
// Self-checking bench for cmd_frame_master: directed vector table,
// mid-frame reset sequence and randomized commands against a model.
module tb_cmd_frame_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  cmd_op_a = '0;
  logic [7:0]  cmd_op_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic [15:0] timeout_lim = '0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        tx_ready = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_timeout;

  always #5 clk = ~clk;

  cmd_frame_master dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_type    (cmd_type),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_op_a    (cmd_op_a),
    .cmd_op_b    (cmd_op_b),
    .cmd_fun     (cmd_fun),
    .timeout_lim (timeout_lim),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .tx_ready    (tx_ready),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_timeout (rsp_timeout)
  );

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  wd, a, b;
    logic [3:0]  fun;
    int          nrx;
    logic [7:0]  rx0, rx1;
    int          gap;
    int          rmode;
    int          lim;
    logic [15:0] exp_data;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int typ, addr, wd, a, b, fun,
                              input int nrx, rx0, rx1, gap, rmode,
                              input int lim, exp_data, exp_to);
    vec_t v;
    v.typ = 2'(typ);  v.addr = 4'(addr); v.wd = 8'(wd);
    v.a = 8'(a);      v.b = 8'(b);       v.fun = 4'(fun);
    v.nrx = nrx;      v.rx0 = 8'(rx0);   v.rx1 = 8'(rx1);
    v.gap = gap;      v.rmode = rmode;   v.lim = lim;
    v.exp_data = 16'(exp_data);
    v.exp_to = exp_to[0];
    v.exp_lat = 0;
    return v;
  endfunction

  function automatic int frame_len(input logic [1:0] t);
    return (t == 2'd0) ? 3 : (t == 2'd2) ? 4 : 2;
  endfunction

  function automatic int req_len(input logic [1:0] t);
    return (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
  endfunction

  function automatic logic [7:0] frame_at(input vec_t v, input int i);
    logic [7:0] f[4];
    f = '{8'h00, 8'h00, 8'h00, 8'h00};
    case (v.typ)
      2'd0: f = '{8'hAA, {4'h0, v.addr}, v.wd, 8'h00};
      2'd1: f = '{8'hBB, {4'h0, v.addr}, 8'h00, 8'h00};
      2'd2: f = '{8'hCC, v.a, v.b, {4'h0, v.fun}};
      default: f = '{8'hDD, {4'h0, v.fun}, 8'h00, 8'h00};
    endcase
    return f[i];
  endfunction

  // Latency counted in cycles after the cycle the last TX byte is taken
  function automatic vec_t model(input vec_t v);
    logic [7:0] rx[2];
    rx[0] = v.rx0;
    rx[1] = v.rx1;
    v.exp_data = '0;
    v.exp_to = 1'b0;
    v.exp_lat = 1;
    for (int i = 0; i < req_len(v.typ); i++) begin
      if (i < v.nrx && (v.lim == 0 || v.gap < v.lim)) begin
        v.exp_data[8*i +: 8] = rx[i];
        v.exp_lat += v.gap + 1;
      end else begin
        v.exp_to = 1'b1;
        v.exp_lat += v.lim;
        break;
      end
    end
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    vec_t m;
    int   len, sent, rel, txcyc, w;
    bit   held, txdone, got, rdy;
    logic [7:0] prev;
    m = model(v);
    len = frame_len(v.typ);
    sent = 0; rel = 0; txcyc = 0; w = 0;
    held = 0; txdone = 0; got = 0;
    prev = '0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, 32'(cmd_ready), 1);
    cmd_type = v.typ;  cmd_addr = v.addr; cmd_wdata = v.wd;
    cmd_op_a = v.a;    cmd_op_b = v.b;    cmd_fun = v.fun;
    timeout_lim = 16'(v.lim);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom);  cmd_addr = 4'($urandom);
    cmd_wdata = 8'($urandom); cmd_op_a = 8'($urandom);
    cmd_op_b = 8'($urandom);  cmd_fun = 4'($urandom);
    for (int cyc = 0; cyc < 400; cyc++) begin
      RX_D_VLD = 1'b0;
      if (txdone) rel++;
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (!txdone) begin
        txcyc++;
        check($sformatf("%s vld%0d", tag, sent), 32'(TX_D_VLD), 1);
        if (held)
          check($sformatf("%s hold%0d", tag, sent), 32'(TX_P_DATA), 32'(prev));
        case (v.rmode)
          0:       rdy = 1;
          1:       rdy = (phase % 3 == 2);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        phase++;
        tx_ready = rdy;
        if (rdy) begin
          check($sformatf("%s byte%0d", tag, sent), 32'(TX_P_DATA),
                32'(frame_at(v, sent)));
          sent++;
          held = 0;
          if (sent == len) txdone = 1;
        end else begin
          held = 1;
          prev = TX_P_DATA;
          if ($urandom_range(0, 3) == 0) begin
            RX_D_VLD = 1'b1;
            RX_P_DATA = 8'($urandom);
          end
        end
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < v.nrx && i < 2; i++) begin
          if (rel == (i + 1) * (v.gap + 1)) begin
            RX_D_VLD = 1'b1;
            RX_P_DATA = (i == 1) ? v.rx1 : v.rx0;
          end
        end
      end
      @(negedge clk);
    end
    RX_D_VLD = 1'b0;
    tx_ready = 1'b0;
    check({tag, " rsp_valid seen"}, 32'(got), 1);
    if (got) begin
      check({tag, " all tx"}, sent, len);
      check({tag, " latency"}, rel, m.exp_lat);
      check({tag, " rsp_data"}, 32'(rsp_data), 32'(v.exp_data));
      check({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
      if (v.rmode == 0) check({tag, " back2back"}, txcyc, len);
      @(negedge clk);
      check({tag, " valid pulse"}, 32'(rsp_valid), 0);
      check({tag, " timeout pulse"}, 32'(rsp_timeout), 0);
      check({tag, " ready again"}, 32'(cmd_ready), 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, " TX_D_VLD"}, 32'(TX_D_VLD), 0);
    check({tag, " TX_P_DATA"}, 32'(TX_P_DATA), 0);
    check({tag, " rsp_data"}, 32'(rsp_data), 0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, " rsp_timeout"}, 32'(rsp_timeout), 0);
  endtask

  vec_t vecs[11];
  vec_t rv;

  initial begin
    vecs[0]  = mk(0, 'h5, 'h3C, 0, 0, 0,       0, 0, 0,        0, 0, 0,  'h0000, 0);
    vecs[1]  = mk(1, 'h2, 0, 0, 0, 0,          1, 'h7E, 0,     20, 0, 0, 'h007E, 0);
    vecs[2]  = mk(2, 0, 0, 'h10, 'h20, 0,      2, 'h30, 'h00,  1, 0, 0,  'h0030, 0);
    vecs[3]  = mk(3, 0, 0, 0, 0, 'h2,          2, 'h11, 'h22,  0, 1, 0,  'h2211, 0);
    vecs[4]  = mk(1, 'h3, 0, 0, 0, 0,          0, 0, 0,        0, 0, 10, 'h0000, 1);
    vecs[5]  = mk(1, 'h9, 0, 0, 0, 0,          1, 'h5A, 0,     3, 2, 4,  'h005A, 0);
    vecs[6]  = mk(2, 0, 0, 'hAB, 'hCD, 'hF,    2, 'h12, 'h34,  4, 2, 4,  'h0000, 1);
    vecs[7]  = mk(2, 0, 0, 'h01, 'h02, 'h3,    1, 'h99, 0,     0, 0, 5,  'h0099, 1);
    vecs[8]  = mk(3, 0, 0, 0, 0, 'hF,          2, 'hFE, 'hEF,  2, 2, 3,  'hEFFE, 0);
    vecs[9]  = mk(0, 'hF, 'hFF, 0, 0, 0,       0, 0, 0,        0, 1, 0,  'h0000, 0);
    vecs[10] = mk(1, 'h0, 0, 0, 0, 0,          1, 'hC3, 0,     0, 0, 1,  'h00C3, 0);

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("post-reset");

    for (int i = 0; i < 11; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset while type2 frame byte 2 is on the wire
    @(negedge clk);
    cmd_type = 2'd2; cmd_op_a = 8'h10; cmd_op_b = 8'h20;
    cmd_fun = 4'h1;  timeout_lim = '0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    check("midrst byte2", 32'(TX_P_DATA), 32'h20);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    run(mk(2, 0, 0, 'h44, 'h55, 'h6, 2, 'hA1, 'hB2, 0, 0, 0, 'hB2A1, 0),
        "after-rst");

    for (int k = 0; k < 40; k++) begin
      rv = mk($urandom_range(0, 3), $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom_range(0, 2), $urandom,
              $urandom, 0, 2, 0, 0, 0);
      if (rv.nrx == 2 && $urandom_range(0, 3) == 0) rv.lim = 0;
      else rv.lim = $urandom_range(1, 8);
      rv.gap = $urandom_range(0, (rv.lim == 0) ? 6 : rv.lim);
      rv = model(rv);
      run(rv, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
